// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared constants and types for the seg_scan_driver block.
//                Optional feature macro: SEG_SCAN_LZB_EN (leading-zero blanking).
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low seven-segment code, bit 0 = segment a ... bit 6 = segment g
  typedef logic [6:0] seg_code_t;

  localparam seg_code_t               SEG_BLANK = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0]   AN_OFF    = 4'b1111;

endpackage : seg_scan_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD nibble to active-low seven-segment lookup.
//                Non-decimal nibbles (0xA-0xF) produce an all-off code.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_code_t  seg
);

  // Table lookup; the default arm keeps invalid digits dark instead of X
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed driver for a 4-digit common-anode display.
//                Double-buffered BCD input, prescaled digit scan, registered
//                active-low anode and segment outputs.
//                Optional feature macro: SEG_SCAN_LZB_EN (leading-zero blanking
//                of digits 3..1; digit 0 is always shown).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DIV_W   = $clog2(CLK_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [15:0]           din,
  input  logic                  blank,
  output logic                  busy,
  output logic                  frame_tick,
  output logic [NUM_DIGITS-1:0] an,
  output seg_code_t             seg
);

  localparam logic [DIV_W-1:0] c_div_max = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [15:0]      r_pend;
  logic [15:0]      r_disp;

  logic                  w_tick;
  logic                  w_boundary;
  logic [3:0]            w_nibble;
  seg_code_t             w_dec;
  logic                  w_suppress;
  seg_code_t             w_seg_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_tick     = (r_div == c_div_max);
  assign w_boundary = w_tick && (r_idx == 2'd3);
  assign w_nibble   = r_disp[{r_idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (w_nibble),
    .seg    (w_dec)
  );

`ifdef SEG_SCAN_LZB_EN
  // Shifting out the lower digits leaves this digit and all higher ones;
  // if that remainder is zero the digit is a leading zero.
  assign w_suppress = (r_idx != 2'd0) && ((r_disp >> {r_idx, 2'b00}) == 16'h0000);
`else
  assign w_suppress = 1'b0;
`endif

  assign w_seg_next = w_suppress ? SEG_BLANK : w_dec;
  assign w_an_next  = blank ? AN_OFF : ~(4'b0001 << r_idx);

  // Prescaler: free-running 0..CLK_DIV-1, one tick per digit slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Digit scan: on each tick light the current digit and move to the next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 2'd0;
      an    <= AN_OFF;
      seg   <= SEG_BLANK;
    end else if (w_tick) begin
      r_idx <= r_idx + 2'd1;
      an    <= w_an_next;
      seg   <= w_seg_next;
    end
  end

  // Double buffer: new values wait in pend and transfer only at a frame
  // boundary so a frame never mixes old and new digits. A load landing on
  // the boundary itself goes straight to disp, superseding any pending value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 16'h0000;
      r_disp <= 16'h0000;
      busy   <= 1'b0;
    end else if (w_boundary) begin
      if (load) begin
        r_disp <= din;
      end else if (busy) begin
        r_disp <= r_pend;
      end
      busy <= 1'b0;
    end else if (load) begin
      r_pend <= din;
      busy   <= 1'b1;
    end
  end

  // Frame pulse: one cycle after each boundary tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_boundary;
    end
  end

endmodule : seg_scan_driver
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Scoreboard bench for seg_scan_driver with CLK_DIV=4.
//                Expected slot contents are queued by the stimulus process and
//                popped by a monitor at every digit-slot update.
//                Honours SEG_SCAN_LZB_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;
  import seg_scan_pkg::*;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic        blank;
  logic        busy;
  logic        frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;

  seg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .blank      (blank),
    .busy       (busy),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int ecount  = 0;   // rising edges since reset release

  typedef struct {
    int         slot;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [15:0] upper;
    upper = v >> (4 * d);
`ifdef SEG_SCAN_LZB_EN
    if (d != 0 && upper == 16'h0000) return 7'b1111111;
`endif
    return dec(upper[3:0]);
  endfunction

  task automatic push_slot(input int s, input logic [15:0] v, input bit blk);
    exp_t       e;
    logic [1:0] d;
    d      = 2'(s % 4);
    e.slot = s;
    e.an   = blk ? 4'b1111 : ~(4'b0001 << d);
    e.seg  = exp_seg(v, int'(d));
    q.push_back(e);
  endtask

  task automatic push_frame(input int first, input logic [15:0] v, input bit blk);
    for (int k = 0; k < 4; k++) push_slot(first + k, v, blk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic at_edge(input int n);
    while (ecount < n) @(negedge clk);
  endtask

  // Assert load in the cycle before edge e so din is captured at edge e
  task automatic drive_load(input int e, input logic [15:0] v);
    at_edge(e - 1);
    load = 1'b1;
    din  = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Monitor: counts edges, checks frame_tick every cycle and pops the
  // scoreboard on every slot update
  initial begin : monitor
    int   s;
    bit   slot_edge;
    bit   exp_ft;
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ecount = 0;
      end else begin
        ecount++;
        slot_edge = (ecount % CLK_DIV == 0);
        s         = ecount / CLK_DIV - 1;
        #1;
        if (!rst) begin
          exp_ft = slot_edge && (s % 4 == 3);
          check("frame_tick", 32'(frame_tick), 32'(exp_ft));
          if (slot_edge) begin
            while (q.size() > 0 && q[0].slot < s) begin
              vectors++;
              fails++;
              $display("FAIL slot_missed: slot %0d never checked, now at slot %0d", q[0].slot, s);
              void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].slot == s) begin
              e = q.pop_front();
              check($sformatf("an_slot%0d", s), 32'(an), 32'(e.an));
              check($sformatf("seg_slot%0d", s), 32'(seg), 32'(e.seg));
            end
          end
        end
      end
    end
  end

  // Watchdog: stimulus is fixed-length, so this only fires on a hang
  initial begin : watchdog
    #50000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin : stim
    rst   = 1'b1;
    load  = 1'b0;
    din   = 16'h0000;
    blank = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_an",         32'(an),         32'hF);
    check("reset_seg",        32'(seg),        32'h7F);
    check("reset_busy",       32'(busy),       32'd0);
    check("reset_frame_tick", 32'(frame_tick), 32'd0);

    // 1: load and first update
    push_frame(0, 16'h0000, 1'b0);
    push_frame(4, 16'h1234, 1'b0);
    rst = 1'b0;
    drive_load(2, 16'h1234);
    check("busy_after_load", 32'(busy), 32'd1);
    at_edge(3);
    check("an_before_first_tick", 32'(an), 32'hF);
    at_edge(15);
    check("busy_before_boundary", 32'(busy), 32'd1);
    at_edge(16);
    check("busy_after_boundary", 32'(busy), 32'd0);

    // 2: load coincident with a boundary
    push_frame(8, 16'h9876, 1'b0);
    drive_load(32, 16'h9876);
    check("busy_load_on_boundary", 32'(busy), 32'd0);

    // 3: invalid nibble, then one fully blanked frame
    push_frame(12, 16'h9876, 1'b0);
    push_frame(16, 16'h00A0, 1'b0);
    push_frame(20, 16'h00A0, 1'b1);
    drive_load(50, 16'h00A0);
    check("busy_load_00a0", 32'(busy), 32'd1);
    at_edge(80);
    blank = 1'b1;
    at_edge(96);
    blank = 1'b0;

    // 4: back-to-back loads, last write wins
    push_frame(24, 16'h00A0, 1'b0);
    push_frame(28, 16'h2222, 1'b0);
    drive_load(98, 16'h1111);
    check("busy_load_1111", 32'(busy), 32'd1);
    drive_load(102, 16'h2222);
    check("busy_load_2222", 32'(busy), 32'd1);
    at_edge(111);
    check("busy_b2b_pending", 32'(busy), 32'd1);
    at_edge(112);
    check("busy_b2b_cleared", 32'(busy), 32'd0);
    at_edge(128);
    check("busy_b2b_stays_clear", 32'(busy), 32'd0);

    // 5: reset in the middle of digit 2 with a value pending
    push_slot(32, 16'h2222, 1'b0);
    push_slot(33, 16'h2222, 1'b0);
    push_slot(34, 16'h2222, 1'b0);
    drive_load(138, 16'h5555);
    check("busy_before_reset", 32'(busy), 32'd1);
    at_edge(141);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_an",   32'(an),   32'hF);
    check("async_reset_seg",  32'(seg),  32'h7F);
    check("async_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // After release the discarded pend must never reach the display;
    // 6: leading-zero patterns follow on the same run
    push_frame(0,  16'h0000, 1'b0);
    push_frame(4,  16'h0000, 1'b0);
    push_frame(8,  16'h0000, 1'b0);
    push_frame(12, 16'h0070, 1'b0);
    push_frame(16, 16'h0000, 1'b0);
    rst = 1'b0;
    at_edge(1);
    check("busy_after_reset_release", 32'(busy), 32'd0);
    at_edge(3);
    check("an_dark_before_first_tick", 32'(an), 32'hF);
    drive_load(34, 16'h0070);
    drive_load(50, 16'h0000);
    at_edge(84);
    @(negedge clk);

    check("scoreboard_drained", 32'(q.size()), 32'd0);
    while (q.size() > 0) begin
      $display("FAIL unchecked_slot: slot %0d still queued", q[0].slot);
      void'(q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule : tb_seg_scan_driver
`default_nettype wire
